// File: rtl/seq_mul16_pkg.sv
// seq_mul16_pkg
//   Shared constants and types for the sequential 16x16 shift-add multiplier.
//   - WIDTH  : operand width (only 16 is supported)
//   - ITERS  : number of add/shift steps per multiply
//   - CNT_W  : width of the step counter
//   - state_t: FSM encodings ST_IDLE / ST_RUN / ST_DONE
package seq_mul16_pkg;

  localparam int WIDTH = 16;
  localparam int ITERS = WIDTH;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla16.sv
// cla16
//   16-bit two-level carry-lookahead adder. It is built from four 4-bit
//   lookahead groups, and a second lookahead level across the group carries.
//   Ports:
//     a, b  : addends (16 bits)
//     cin   : carry in
//     sum   : a + b + cin, low 16 bits
//     cout  : carry out of bit 15
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate for each 4-bit slice.
  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
  end

  // Second level: every group carry is computed directly from cin.
  always_comb begin
    cg    = '0;
    cg[0] = cin;
    cg[1] = gg[0] | (gp[0] & cin);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  // Carries inside each group are formed by lookahead from the group carry-in.
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = cg[4];

endmodule

// File: rtl/seq_mul16_shift_add_step.sv
// shift_add_step
//   Combinational step of the shift-add multiplier. When p0 is set, the
//   multiplicand is added to the upper half through the carry-lookahead
//   adder, with carry-in tied to 0. The 33-bit value {carry, hi, lo} is then
//   shifted right by one bit.
//   Ports:
//     hi      : upper half of the partial product P[31:16]
//     lo      : lower half of the partial product P[15:0]
//     m       : latched multiplicand
//     p0      : current P[0], selects add or pass-through
//     hi_next : next P[31:16]; bit 15 is the adder carry-out
//     lo_next : next P[15:0]
//     c_out   : carry of this step (0 when no add happened)
module shift_add_step
  import seq_mul16_pkg::*;
(
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] m,
  input  logic             p0,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             c_out
);

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] sel_hi;
  logic             sel_c;
  logic             unused_lo0;

  cla16 u_cla (
    .a    (hi),
    .b    (m),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    sel_hi = hi;
    sel_c  = 1'b0;
    if (p0) begin
      sel_hi = add_sum;
      sel_c  = add_cout;
    end
  end

  // The bit shifted out of lo has already been consumed as p0.
  assign unused_lo0 = lo[0];

  assign hi_next = {sel_c, sel_hi[WIDTH-1:1]};
  assign lo_next = {sel_hi[0], lo[WIDTH-1:1]};
  assign c_out   = sel_c;

endmodule

// File: rtl/seq_mul16.sv
// seq_mul16
//   Sequential unsigned 16x16 -> 32 shift-add multiplier. It performs one
//   conditional add-and-shift per clock through the 16-bit CLA adder.
//   Optional build macro: MUL_ZERO_BYPASS_EN. When it is defined, a start
//   with a zero operand completes in one cycle and never enters RUN.
//   Handshake: start is sampled only in IDLE or DONE; while RUN is active it
//   is ignored. busy is high in RUN. done is a one-cycle pulse in DONE, and
//   Product is valid from done until the next accepted operation completes.
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : synchronous active-low reset
//     start     : operation request
//     A, B      : multiplicand / multiplier, latched on an accepted start
//     busy      : high while stepping (exactly ITERS cycles)
//     done      : result pulse
//     Product   : 32-bit result register
//     dbg_state : current FSM state, for observation
module seq_mul16
  import seq_mul16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product,
  output state_t             dbg_state
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               c_q;
  logic [2*WIDTH-1:0] product_q;

  logic               load;
  logic               step;
  logic               last_step;
  logic               zero_load;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic               c_next;

  shift_add_step u_step (
    .hi      (p_q[2*WIDTH-1:WIDTH]),
    .lo      (p_q[WIDTH-1:0]),
    .m       (m_q),
    .p0      (p_q[0]),
    .hi_next (hi_next),
    .lo_next (lo_next),
    .c_out   (c_next)
  );

  assign last_step = (cnt_q == CNT_LAST);

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    zero_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
`ifdef MUL_ZERO_BYPASS_EN
          if ((A == '0) || (B == '0)) begin
            zero_load = 1'b1;
            state_d   = ST_DONE;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_step) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        m_q   <= A;
        p_q   <= {{WIDTH{1'b0}}, B};
        cnt_q <= '0;
        c_q   <= 1'b0;
        // A zero operand gives the result immediately; it is published
        // together with the entry to DONE.
        if (zero_load) begin
          p_q       <= '0;
          product_q <= '0;
        end
      end else if (step) begin
        p_q   <= {hi_next, lo_next};
        c_q   <= c_next;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) begin
          product_q <= {hi_next, lo_next};
        end
      end
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign Product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_mul16.sv
module tb_seq_mul16;
  import seq_mul16_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] Product;
  state_t      dbg_state;

  always #5 clk = ~clk;

  seq_mul16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Product   (Product),
    .dbg_state (dbg_state)
  );

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (busy && done) begin
        bad++;
        $display("FAIL busy_done_overlap: busy=%b done=%b expected not both", busy, done);
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    string       name;
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  // Drives one operation and watches it to completion. The k-th negedge
  // after start is raised shows the state after edge E(k-1).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] prod, input string name);
    int          lat;
    int          bcnt;
    bit          seen;
    bit          zero;
    logic [31:0] want;
    zero = (a == 16'h0) || (b == 16'h0);
    exp_q.push_back(prod);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    lat = 0;
    bcnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      A = 16'($urandom_range(0, 65535));
      B = 16'($urandom_range(0, 65535));
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        lat = k;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), (zero && BYPASS) ? 32'd1 : 32'd17);
    check({name, "_busy_cycles"}, 32'(bcnt), (zero && BYPASS) ? 32'd0 : 32'd16);
    want = exp_q.pop_front();
    check({name, "_product"}, Product, want);
    @(negedge clk);
    check({name, "_done_pulse_end"}, 32'(done), 32'd0);
    check({name, "_back_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic expect_quiet(input int n, input string name);
    int dcnt;
    dcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check(name, 32'(dcnt), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int   k;
    bit   seen;
    int   t1;
    int   t2;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, "v3x5"};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, "vffffxffff"};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, "v1234x0"};
    vecs[3] = '{16'h0000, 16'hBEEF, 32'h00000000, "v0xbeef"};
    vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000FFFF, "v1xffff"};
    vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, "v8000x8000"};
    vecs[6] = '{16'h00FF, 16'h0101, 32'h0000FFFF, "vffx101"};

    // reset state, with start held high to show that reset wins
    start = 1'b1;
    A = 16'h0003;
    B = 16'h0005;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", Product, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    start = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].name);
    end

    // Product is held between results
    repeat (3) @(negedge clk);
    check("product_hold", Product, 32'h0000FFFF);

    // start during RUN is ignored
    @(negedge clk);
    A = 16'h00FF;
    B = 16'h0101;
    start = 1'b1;
    seen = 1'b0;
    k = 0;
    for (int j = 1; j <= 40 && !seen; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 5) begin
        A = 16'h0007;
        B = 16'h0007;
        start = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        k = j;
      end
    end
    check("ign_latency", 32'(k), 32'd17);
    check("ign_product", Product, 32'h0000FFFF);
    start = 1'b0;
    expect_quiet(20, "ign_no_second_done");

    // reset in the middle of RUN
    @(negedge clk);
    A = 16'hABCD;
    B = 16'h1234;
    start = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", Product, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    expect_quiet(20, "midrst_no_done");

    // back-to-back operation
    @(negedge clk);
    A = 16'h0002;
    B = 16'h0003;
    start = 1'b1;
    t1 = 0;
    t2 = 0;
    for (int j = 1; j <= 60 && t2 == 0; j++) begin
      @(negedge clk);
      if (done) begin
        if (t1 == 0) begin
          t1 = j;
          check("b2b_first_product", Product, 32'h00000006);
          A = 16'h8000;
          B = 16'h0002;
        end else begin
          t2 = j;
          check("b2b_second_product", Product, 32'h00010000);
        end
      end else if (t1 != 0) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 32'(t1), 32'd17);
    check("b2b_interval", 32'(t2 - t1), 32'd17);
    @(negedge clk);
    check("b2b_end_idle", 32'(dbg_state), 32'(ST_IDLE));

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
